// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end.
//
// Pulls fetch addresses from the PC register, issues them to instruction
// memory over a req/gnt/rvalid bus and buffers the returned words together
// with their addresses. Decode sees the words in program order over a
// valid/ready handshake. A jump flushes the buffer and marks every in-flight
// request so that its response is dropped when it arrives.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   pc, jump                fetch address and redirect from the PC register
//   stall_n                 1 = PC register advances this cycle
//   imem_req/addr/gnt       request channel to instruction memory
//   imem_rvalid/rdata       in-order response channel
//   id_valid/ready/instr/pc decode-side handshake and payload

// Checks that the memory never answers a request that was not made.
module ifetch_unit_chk (
  input logic clk,
  input logic rst_n,
  input logic imem_rvalid,
  input logic out_empty
);
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
                                       !(imem_rvalid && out_empty));
endmodule

module ifetch_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc,
  input  logic          jump,
  output logic          stall_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [AW-1:0] imem_rdata,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [AW-1:0] id_instr,
  output logic [AW-1:0] id_pc
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  // Run flag: holds requests off until the first edge after reset release.
  logic          active_q;
  logic [CW-1:0] out_cnt_q,  out_cnt_d;
  logic [CW-1:0] disc_cnt_q, disc_cnt_d;
  logic [AW-1:0] pcq_mem_q [DEPTH];
  logic [AW-1:0] pcq_mem_d [DEPTH];
  logic [PW-1:0] pcq_wr_q, pcq_wr_d;
  logic [PW-1:0] pcq_rd_q, pcq_rd_d;
  logic [AW-1:0] fifo_instr_q [DEPTH];
  logic [AW-1:0] fifo_instr_d [DEPTH];
  logic [AW-1:0] fifo_pc_q [DEPTH];
  logic [AW-1:0] fifo_pc_d [DEPTH];
  logic [PW-1:0] fifo_wr_q, fifo_wr_d;
  logic [PW-1:0] fifo_rd_q, fifo_rd_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic          id_valid_q, id_valid_d;

  logic [SW-1:0] credit_sum_s;
  logic          accept_s;
  logic          rsp_s;
  logic          keep_s;
  logic          pop_s;

  // Issue credit, handshake qualifiers and the combinational bus outputs.
  always_comb begin
    // Credits count in-flight requests (discarded ones included) plus
    // buffered words, so the output FIFO can never overflow.
    credit_sum_s = SW'(out_cnt_q) + SW'(fifo_cnt_q);
    imem_req     = active_q && !jump && (credit_sum_s < DEPTH_S);
    accept_s     = imem_req && imem_gnt;
    stall_n      = accept_s;
    imem_addr    = pc;
    rsp_s        = imem_rvalid && (out_cnt_q != CNT_ZERO);
    keep_s       = rsp_s && !jump && (disc_cnt_q == CNT_ZERO);
    pop_s        = id_valid_q && id_ready && !jump;
  end

  // Outstanding and discard counters.
  always_comb begin
    out_cnt_d  = out_cnt_q;
    disc_cnt_d = disc_cnt_q;
    if (accept_s && !rsp_s) begin
      out_cnt_d = out_cnt_q + CNT_ONE;
    end else if (!accept_s && rsp_s) begin
      out_cnt_d = out_cnt_q - CNT_ONE;
    end else begin
      out_cnt_d = out_cnt_q;
    end
    // Everything still in flight after this edge belongs to the old stream.
    if (jump) begin
      disc_cnt_d = out_cnt_q - CW'(rsp_s);
    end else if (rsp_s && (disc_cnt_q != CNT_ZERO)) begin
      disc_cnt_d = disc_cnt_q - CNT_ONE;
    end else begin
      disc_cnt_d = disc_cnt_q;
    end
  end

  // Address queue: one entry per outstanding request, popped by each
  // response (discarded ones too, so it stays aligned across a flush).
  always_comb begin
    pcq_mem_d = pcq_mem_q;
    pcq_wr_d  = pcq_wr_q;
    pcq_rd_d  = pcq_rd_q;
    if (accept_s) begin
      pcq_mem_d[pcq_wr_q] = pc;
      pcq_wr_d            = pcq_wr_q + PTR_ONE;
    end else begin
      pcq_wr_d = pcq_wr_q;
    end
    if (rsp_s) begin
      pcq_rd_d = pcq_rd_q + PTR_ONE;
    end else begin
      pcq_rd_d = pcq_rd_q;
    end
  end

  // Output FIFO of {instr, pc}; a jump empties it and suppresses push/pop.
  always_comb begin
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_wr_d    = fifo_wr_q;
    fifo_rd_d    = fifo_rd_q;
    fifo_cnt_d   = fifo_cnt_q;
    if (jump) begin
      fifo_wr_d  = PTR_ZERO;
      fifo_rd_d  = PTR_ZERO;
      fifo_cnt_d = CNT_ZERO;
    end else begin
      if (keep_s) begin
        fifo_instr_d[fifo_wr_q] = imem_rdata;
        fifo_pc_d[fifo_wr_q]    = pcq_mem_q[pcq_rd_q];
        fifo_wr_d               = fifo_wr_q + PTR_ONE;
      end else begin
        fifo_wr_d = fifo_wr_q;
      end
      if (pop_s) begin
        fifo_rd_d = fifo_rd_q + PTR_ONE;
      end else begin
        fifo_rd_d = fifo_rd_q;
      end
      fifo_cnt_d = fifo_cnt_q + CW'(keep_s) - CW'(pop_s);
    end
    id_valid_d = (fifo_cnt_d != CNT_ZERO);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      out_cnt_q  <= CNT_ZERO;
      disc_cnt_q <= CNT_ZERO;
      pcq_wr_q   <= PTR_ZERO;
      pcq_rd_q   <= PTR_ZERO;
      fifo_wr_q  <= PTR_ZERO;
      fifo_rd_q  <= PTR_ZERO;
      fifo_cnt_q <= CNT_ZERO;
      id_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pcq_mem_q[i]    <= {AW{1'b0}};
        fifo_instr_q[i] <= {AW{1'b0}};
        fifo_pc_q[i]    <= {AW{1'b0}};
      end
    end else begin
      active_q     <= 1'b1;
      out_cnt_q    <= out_cnt_d;
      disc_cnt_q   <= disc_cnt_d;
      pcq_wr_q     <= pcq_wr_d;
      pcq_rd_q     <= pcq_rd_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_cnt_q   <= fifo_cnt_d;
      id_valid_q   <= id_valid_d;
      pcq_mem_q    <= pcq_mem_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_instr = fifo_instr_q[fifo_rd_q];
  assign id_pc    = fifo_pc_q[fifo_rd_q];

  ifetch_unit_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_rvalid (imem_rvalid),
    .out_empty   (out_cnt_q == CNT_ZERO)
  );

endmodule
